// File: rtl/reg8to256_pkg.sv
// reg8to256_pkg: shared constants and helpers for the byte<->wide word packers
package reg8to256_pkg;
  localparam int BYTES_PER_WORD = 32;
  localparam int WORD_W = BYTES_PER_WORD * 8;
  function automatic int fill_w(input int bytes);
    return $clog2(bytes + 1);
  endfunction
  localparam int FILL_W = fill_w(63);
endpackage

// File: rtl/reg8to256_outbuf.sv
// reg8to256_outbuf: single-entry output holding register with valid/ready handshake
module reg8to256_outbuf #(
  parameter int W = 256
) (
  input  logic         wrclock,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         can_load
);
  assign can_load = !valid || ready;
  // capture a new word on load; otherwise hold until the consumer takes it
  always_ff @(posedge wrclock or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/reg8to256.sv
// reg8to256: packs 32 bytes (first byte in MSBs) into a 256-bit word; REG8TO256_FLUSH_EN enables padded partial-word flush
module reg8to256
  import reg8to256_pkg::*;
#(
  parameter int         BYTES = BYTES_PER_WORD,
  parameter logic [7:0] PAD   = 8'h00
) (
  input  logic                 wrclock,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic [7:0]           din,
  output logic                 din_ready,
  input  logic                 word_ready,
  output logic                 word_valid,
  output logic [BYTES*8-1:0]   data256,
  output logic [FILL_W-1:0]    fill,
  input  logic                 flush
);
  localparam int W = BYTES * 8;
  localparam logic [FILL_W-1:0] LAST = FILL_W'(BYTES - 1);
  logic [W-1:0] acc, acc_nxt, word_nxt;
  logic rdy_en, last, accept, complete, can_load, load, flush_req;
`ifdef REG8TO256_FLUSH_EN
  logic pend;
  assign flush_req = (flush || pend) && fill != '0;
  // remember a flush that could not load because the output was still occupied
  always_ff @(posedge wrclock or negedge rst_n)
    if (!rst_n) pend <= 1'b0;
    else pend <= flush_req && !can_load;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_req = 1'b0;
`endif
  assign last      = fill == LAST;
  assign din_ready = rdy_en && !(last && word_valid && !word_ready) && !(flush_req && !can_load);
  assign accept    = din_valid && din_ready;
  assign complete  = accept && last;
  assign load      = complete || (flush_req && can_load);
  // merge the incoming byte into the accumulator and build the outgoing (padded) word
  always_comb begin
    acc_nxt = acc;
    word_nxt = '0;
    for (int i = 0; i < BYTES; i++) begin
      acc_nxt[(BYTES-1-i)*8 +: 8] = FILL_W'(i) == fill ? din : acc[(BYTES-1-i)*8 +: 8];
      word_nxt[(BYTES-1-i)*8 +: 8] = FILL_W'(i) < fill ? acc[(BYTES-1-i)*8 +: 8] :
                                     (FILL_W'(i) == fill && accept) ? din : PAD;
    end
  end
  // intake is held off until the first edge after reset release
  always_ff @(posedge wrclock or negedge rst_n)
    if (!rst_n) rdy_en <= 1'b0;
    else rdy_en <= 1'b1;
  // accumulator and byte count; a loaded word restarts the accumulator empty
  always_ff @(posedge wrclock or negedge rst_n)
    if (!rst_n) begin
      fill <= '0;
      acc <= '0;
    end else if (load) begin
      fill <= '0;
      acc <= '0;
    end else if (accept) begin
      fill <= fill + 1'b1;
      acc <= acc_nxt;
    end
  reg8to256_outbuf #(.W(W)) u_outbuf (
    .wrclock  (wrclock),
    .rst_n    (rst_n),
    .load     (load),
    .d        (word_nxt),
    .ready    (word_ready),
    .valid    (word_valid),
    .q        (data256),
    .can_load (can_load)
  );
endmodule
